// File: rtl/copper_list_sequencer.sv
// Copper list engine: replays a host-loaded {line, colour} table once per frame as the background colour.
// Optional build macro COPPER_GRADIENT_EN adds a per-entry colour step applied on every non-applying line.
module copper_list_sequencer #(
  parameter int          COORD_WIDTH   = 16,
  parameter int          ENTRIES       = 16,
  parameter logic [23:0] DEFAULT_COLOR = 24'h000000,
  localparam int         AW            = $clog2(ENTRIES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vsync,
  input  logic                          hsync,
  input  logic signed [COORD_WIDTH-1:0] y,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [AW-1:0]                 wr_addr,
  input  logic signed [COORD_WIDTH-1:0] wr_line,
  input  logic [23:0]                   wr_color,
`ifdef COPPER_GRADIENT_EN
  input  logic [23:0]                   wr_step,
`endif
  input  logic                          len_wr,
  input  logic [AW:0]                   len,
  output logic [23:0]                   color_rgb,
  output logic                          list_active
);

`ifdef COPPER_GRADIENT_EN
  localparam int DW = COORD_WIDTH + 48;
`else
  localparam int DW = COORD_WIDTH + 24;
`endif

  typedef enum logic [2:0] {IDLE, ARM, FETCH, WAIT, DONE} state_t;

  state_t                        state;
  logic                          hsync_q, vsync_q;
  logic [AW:0]                   pend_len, act_len;
  logic [AW-1:0]                 ptr;
  logic signed [COORD_WIDTH-1:0] next_line;
  logic [23:0]                   next_color;
  logic [DW-1:0]                 mem [ENTRIES];
  logic [DW-1:0]                 rd_q;
  logic [DW-1:0]                 wr_word;
  logic [AW:0]                   len_c;

  wire h_rise  = hsync & ~hsync_q;
  wire v_rise  = vsync & ~vsync_q;
  wire wr_fire = wr_valid & wr_ready;
  wire last    = ({1'b0, ptr} == act_len - (AW+1)'(1));
  wire hit     = h_rise && ($signed(y) >= next_line);

`ifdef COPPER_GRADIENT_EN
  logic [23:0] step, next_step;
  assign wr_word = {wr_line, wr_color, wr_step};
`else
  assign wr_word = {wr_line, wr_color};
`endif

  assign len_c = (len > (AW+1)'(ENTRIES)) ? (AW+1)'(ENTRIES) : len;

  // Single-port RAM: writes are blocked in ARM, so the read never collides with a write.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= wr_word;
    if (state == ARM) rd_q <= mem[ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      pend_len    <= '0;
      act_len     <= '0;
      ptr         <= '0;
      next_line   <= '0;
      next_color  <= '0;
      color_rgb   <= DEFAULT_COLOR;
      list_active <= 1'b0;
      wr_ready    <= 1'b1;
`ifdef COPPER_GRADIENT_EN
      step        <= '0;
      next_step   <= '0;
`endif
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      if (len_wr) pend_len <= len_c;
      // Frame start restarts the list from any state and wins over a coincident h_rise.
      if (v_rise) begin
        color_rgb <= DEFAULT_COLOR;
        act_len   <= pend_len;
        ptr       <= '0;
`ifdef COPPER_GRADIENT_EN
        step      <= '0;
`endif
        if (pend_len != '0) begin
          state       <= ARM;
          list_active <= 1'b1;
          wr_ready    <= 1'b0;
        end else begin
          state       <= IDLE;
          list_active <= 1'b0;
          wr_ready    <= 1'b1;
        end
      end else begin
        case (state)
          ARM: begin
            state    <= FETCH;
            wr_ready <= 1'b1;
          end
          FETCH: begin
`ifdef COPPER_GRADIENT_EN
            {next_line, next_color, next_step} <= rd_q;
`else
            {next_line, next_color} <= rd_q;
`endif
            state <= WAIT;
          end
          WAIT: begin
            if (hit) begin
              color_rgb <= next_color;
`ifdef COPPER_GRADIENT_EN
              step      <= next_step;
`endif
              if (last) begin
                state       <= DONE;
                list_active <= 1'b0;
              end else begin
                ptr      <= ptr + 1'b1;
                state    <= ARM;
                wr_ready <= 1'b0;
              end
            end
`ifdef COPPER_GRADIENT_EN
            else if (h_rise) color_rgb <= color_rgb + step;
`endif
          end
          DONE: begin
`ifdef COPPER_GRADIENT_EN
            if (h_rise) color_rgb <= color_rgb + step;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
